shift_unit_ctrl: RTL and testbench
==================================

# shift_unit_ctrl

Sequencing controller for the CPU's shared 32-bit left-only barrel shifter. It accepts one shift request at a time over a valid/ready handshake. Right shifts are built from bit reversal, and arithmetic-right and rotate ops use a second pass through the same shifter. It returns a registered result over a second valid/ready handshake. The block sits in the EX stage beside the ALU and is the only user of the shifter instance.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `SHW`, 5: shift-amount width, log2(XLEN).

Ports:
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: reset. **Synchronous, active-high; one clock domain.**
- `req_valid` input, 1: request present.
- `req_ready` output, 1: controller can accept a request.
- `req_op` input, 3: 0 SLL, 1 SRL, 2 SRA, 3 ROTL, 4 ROTR; 5–7 are illegal.
- `req_data` input, 32: operand.
- `req_shamt` input, 5: shift amount.
- `resp_valid` output, 1: result available.
- `resp_ready` input, 1: consumer takes the result.
- `resp_result` output, 32: shifted value.
- `resp_err` output, 1: op was illegal or compiled out.
- `busy` output, 1: state is not IDLE.

## Operation
States: IDLE, PASS1, PASS2, DONE.
- **IDLE:** `req_ready`=1. On `req_valid`: register op, data and shamt, then go to PASS1. All other inputs are ignored.
- **PASS1:** drive the shifter and capture its output into temp (t).
  - SLL: input data, amount shamt.
  - SRL, SRA, ROTR: input rev(data), amount shamt; t = rev(out).
  - ROTL: input data, amount shamt.
  - Next state: SLL/SRL go to DONE with result = t. SRA/ROTL/ROTR go to PASS2. Illegal ops go to DONE with result = data and err=1.
- **PASS2:**
  - SRA: shifter input 0xFFFF_FFFF, amount shamt; m = rev(out); result = t | (data[31] ? ~m : 0).
  - ROTL: shifter input rev(data), amount (32−shamt) mod 32; result = t | rev(out).
  - ROTR: t already holds data>>shamt; shifter input data, amount (32−shamt) mod 32; result = t | out.
  - Go to DONE.
- **DONE:** `resp_valid`=1. `resp_result` and `resp_err` stay stable until `resp_valid & resp_ready`, then go to IDLE.
- Shift amount 0: every op returns data unchanged. Rotates rely on t|t = t.
- `rev()` is a pure wiring bit reversal; no arithmetic beyond 5-bit modulo subtraction.
- Reset at any point, including mid-PASS2 or while holding DONE: the in-flight op is discarded with no response.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_result`=0, `resp_err`=0, `busy`=0.
- Request accepted at the end of cycle N.
- SLL, SRL and illegal ops: `resp_valid` high in cycle N+2.
- SRA, ROTL, ROTR: `resp_valid` high in cycle N+3.
- `req_ready` is 0 from N+1 until the cycle after the response handshake, so there is no overlap. Peak throughput is one op per 3 or 4 cycles.
- With `resp_ready` held at 1, `resp_valid` is high for exactly one cycle.
- All outputs are registered or decoded directly from state; there is no combinational input-to-output path.

## Configuration
- `SHIFT_ROTATE_EN` defined: ROTL/ROTR are implemented as described above.
- Not defined: ops 3 and 4 are treated as illegal (single pass, result = data, `resp_err`=1), and the PASS2 rotate muxing is removed.

## Structure
- Package `shift_ctrl_pkg` holds:
  - op encoding constants `OP_SLL` … `OP_ROTR`;
  - state enum;
  - `ALL_ONES32`.
- Sub-modules:
  - one instance of the existing `barrel_shifter_32bit`, with its input and amount muxed by state/op;
  - one combinational helper `bit_rev32`, instantiated for the input and output reversal paths.

## Test plan
- SLL, data 0x0000_0001, shamt 31 → `resp_result`=0x8000_0000, `resp_err`=0, `resp_valid` in N+2.
- SRL, data 0x8000_0000, shamt 31 → 0x0000_0001 in N+2. SRA, data 0x8000_0000, shamt 4 → 0xF800_0000 in N+3.
- SRA, data 0x7000_0000, shamt 4 → 0x0700_0000. Any op with shamt 0 → data unchanged.
- Backpressure: hold `resp_ready`=0 for 5 cycles while `req_valid`=1 with a new op. Expect result and valid stable, `req_ready`=0, and the new op accepted only after the handshake.
- Assert `rst` during PASS2 of an SRA. Next cycle: `req_ready`=1, `resp_valid`=0, result 0, and no response appears. A following SLL completes normally.
- With `SHIFT_ROTATE_EN`: ROTL, data 0x8000_0001, shamt 4 → 0x0000_0018; ROTR, same data, shamt 4 → 0x1800_0000. Without it: op 3 → `resp_err`=1, result 0x8000_0001 in N+2.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift sequencing controller: op encodings,
// FSM state type, constants and op-classification helpers.
// Optional feature macro: SHIFT_ROTATE_EN (enables ROTL/ROTR).
package shift_ctrl_pkg;

  localparam logic [2:0] OP_SLL  = 3'd0;
  localparam logic [2:0] OP_SRL  = 3'd1;
  localparam logic [2:0] OP_SRA  = 3'd2;
  localparam logic [2:0] OP_ROTL = 3'd3;
  localparam logic [2:0] OP_ROTR = 3'd4;

  localparam logic [31:0] ALL_ONES32 = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // An op is legal if it is one this build actually implements.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op <= OP_ROTR);
`else
    return (op <= OP_SRA);
`endif
  endfunction

  // Ops that need a second trip through the shifter.
  function automatic logic op_two_pass(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op == OP_SRA) || (op == OP_ROTL) || (op == OP_ROTR);
`else
    return (op == OP_SRA);
`endif
  endfunction

  // Ops whose first pass works on bit-reversed data (right-direction shifts).
  function automatic logic op_rev_pass1(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROTR);
`else
    return (op == OP_SRL) || (op == OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/barrel_shifter_32bit.sv
// Combinational 32-bit left-only logarithmic barrel shifter (zero fill).
module barrel_shifter_32bit (
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] data_o
);

  logic [31:0] stg;

  // Five binary-weighted shift stages selected by the amount bits.
  always_comb begin
    stg = data_i;
    for (int k = 0; k < 5; k++) begin
      if (shamt_i[k]) stg = stg << (1 << k);
    end
    data_o = stg;
  end

endmodule

// File: rtl/bit_rev32.sv
// Pure wiring 32-bit bit reversal: out[i] = in[31-i].
module bit_rev32 (
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  for (genvar i = 0; i < 32; i++) begin : g_rev
    assign data_o[i] = data_i[31-i];
  end

endmodule

// File: rtl/shift_unit_ctrl.sv
// Sequencing controller around the shared left-only barrel shifter.
// Right shifts use bit reversal; SRA and rotates take a second pass.
// Optional feature macro: SHIFT_ROTATE_EN (ROTL/ROTR; otherwise ops 3/4
// are reported as illegal).
module shift_unit_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_data,
  input  logic [SHW-1:0]  req_shamt,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_err,
  output logic            busy
);

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] data_q;
  logic [4:0]  shamt_q;
  logic [31:0] t_q;
  logic [31:0] result_q;
  logic        err_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        busy_q;

  logic [31:0] data_rev;
  logic [31:0] sh_in;
  logic [4:0]  sh_amt;
  logic [31:0] sh_out;
  logic [31:0] out_rev;
  logic [31:0] pass1_res;
  logic [31:0] pass2_res;

`ifdef SHIFT_ROTATE_EN
  // Complementary rotate amount, (32 - shamt) mod 32, falls out of 5-bit wrap.
  logic [4:0]  shamt_inv;
  assign shamt_inv = 5'd0 - shamt_q;
`endif

  bit_rev32 u_rev_in (
    .data_i (data_q),
    .data_o (data_rev)
  );

  barrel_shifter_32bit u_shifter (
    .data_i  (sh_in),
    .shamt_i (sh_amt),
    .data_o  (sh_out)
  );

  bit_rev32 u_rev_out (
    .data_i (sh_out),
    .data_o (out_rev)
  );

  // Shifter operand/amount selection by state and registered op.
  always_comb begin
    sh_in  = data_q;
    sh_amt = shamt_q;
    case (state_q)
      ST_PASS1: begin
        if (op_rev_pass1(op_q)) sh_in = data_rev;
      end
      ST_PASS2: begin
        case (op_q)
          OP_SRA: sh_in = ALL_ONES32;
`ifdef SHIFT_ROTATE_EN
          OP_ROTL: begin
            sh_in  = data_rev;
            sh_amt = shamt_inv;
          end
          OP_ROTR: begin
            sh_in  = data_q;
            sh_amt = shamt_inv;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Pass results: first pass un-reverses right shifts; second pass merges.
  always_comb begin
    pass1_res = op_rev_pass1(op_q) ? out_rev : sh_out;
    pass2_res = t_q;
    case (op_q)
      // out_rev = ones >> shamt, so its complement is the sign-fill mask.
      OP_SRA:  pass2_res = t_q | (data_q[31] ? ~out_rev : 32'h0);
`ifdef SHIFT_ROTATE_EN
      OP_ROTL: pass2_res = t_q | out_rev;
      OP_ROTR: pass2_res = t_q | sh_out;
`endif
      default: ;
    endcase
  end

  // Request operands and first-pass temp; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req_valid) begin
      op_q    <= req_op;
      data_q  <= req_data;
      shamt_q <= req_shamt;
    end
    if (state_q == ST_PASS1) t_q <= pass1_res;
  end

  // Control FSM with registered handshake flags and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      result_q     <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_PASS1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_PASS1: begin
          if (!op_legal(op_q)) begin
            result_q     <= data_q;
            err_q        <= 1'b1;
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
          end else if (op_two_pass(op_q)) begin
            state_q <= ST_PASS2;
          end else begin
            result_q     <= pass1_res;
            err_q        <= 1'b0;
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
          end
        end
        ST_PASS2: begin
          result_q     <= pass2_res;
          err_q        <= 1'b0;
          state_q      <= ST_DONE;
          resp_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Directed bench for shift_unit_ctrl with a response scoreboard.
// Honors SHIFT_ROTATE_EN the same way the design does.
module tb_shift_unit_ctrl;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic [4:0]  req_shamt;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        busy;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  shift_unit_ctrl #(.XLEN(32), .SHW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_shamt   (req_shamt),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: native shift/rotate operators.
  function automatic void model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                                output logic [31:0] r, output logic e, output int lat);
    int si;
    si  = int'(s);
    e   = 1'b0;
    lat = 2;
    case (op)
      3'd0: r = d << si;
      3'd1: r = d >> si;
      3'd2: begin r = $unsigned($signed(d) >>> si); lat = 3; end
      3'd3: begin r = (si == 0) ? d : ((d << si) | (d >> (32 - si))); lat = 3; end
      3'd4: begin r = (si == 0) ? d : ((d >> si) | (d << (32 - si))); lat = 3; end
      default: begin r = d; e = 1'b1; end
    endcase
    if ((op == 3'd3 || op == 3'd4) && !ROT_EN) begin
      r = d; e = 1'b1; lat = 2;
    end
  endfunction

  // Called at the negedge of cycle N+1; waits for the response and scores it.
  task automatic wait_resp(input string tag);
    int   cyc;
    exp_t e;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_lat"}, cyc, e.lat);
      check({tag, "_res"}, resp_result, e.res);
      check({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
    end
  endtask

  // Full transaction with resp_ready held high; starts and ends at a negedge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_res, input logic exp_err,
                        input int exp_lat);
    exp_t e;
    e.res = exp_res; e.err = exp_err; e.lat = exp_lat;
    sb_q.push_back(e);
    check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_data   = d;
    req_shamt  = s;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(tag);
    @(negedge clk);
    check({tag, "_vld1cyc"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_rdy_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic run_model(input string tag, input logic [2:0] op, input logic [31:0] d,
                           input logic [4:0] s);
    logic [31:0] r;
    logic        e;
    int          lat;
    model(op, d, s, r, e, lat);
    run_op(tag, op, d, s, r, e, lat);
  endtask

  initial begin
    int vcount;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_data   = 32'h0;
    req_shamt  = 5'd0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_result", resp_result, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations.
    run_op("sll31", 3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 2);
    run_op("srl31", 3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 2);
    run_op("sra_neg", 3'd2, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 3);
    run_op("sra_pos", 3'd2, 32'h7000_0000, 5'd4, 32'h0700_0000, 1'b0, 3);
    run_op("sll0", 3'd0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 2);
    run_op("srl0", 3'd1, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 2);
    run_op("sra0", 3'd2, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 3);
    run_op("illegal6", 3'd6, 32'h1234_5678, 5'd3, 32'h1234_5678, 1'b1, 2);
`ifdef SHIFT_ROTATE_EN
    run_op("rotl4", 3'd3, 32'h8000_0001, 5'd4, 32'h0000_0018, 1'b0, 3);
    run_op("rotr4", 3'd4, 32'h8000_0001, 5'd4, 32'h1800_0000, 1'b0, 3);
    run_op("rotl0", 3'd3, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 1'b0, 3);
    run_op("rotr0", 3'd4, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 1'b0, 3);
`else
    run_op("op3_off", 3'd3, 32'h8000_0001, 5'd4, 32'h8000_0001, 1'b1, 2);
    run_op("op4_off", 3'd4, 32'h8000_0001, 5'd4, 32'h8000_0001, 1'b1, 2);
`endif

    // Mixed operands scored against the reference model.
    for (int i = 0; i < 10; i++) begin
      run_model($sformatf("rnd%0d", i), 3'($urandom_range(0, 4)), $urandom, 5'($urandom_range(0, 31)));
    end

    // Backpressure: response held while a new request waits.
    begin
      exp_t e;
      e.res = 32'hF800_0000; e.err = 1'b0; e.lat = 3;
      sb_q.push_back(e);
      req_valid  = 1'b1;
      req_op     = 3'd2;
      req_data   = 32'h8000_0000;
      req_shamt  = 5'd4;
      resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_op    = 3'd0;
      req_data  = 32'h0000_0001;
      req_shamt = 5'd31;
      wait_resp("bp_sra");
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("bp_hold_vld%0d", k), {31'b0, resp_valid}, 32'd1);
        check($sformatf("bp_hold_res%0d", k), resp_result, 32'hF800_0000);
        check($sformatf("bp_hold_rdy%0d", k), {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("bp_after_vld", {31'b0, resp_valid}, 32'd0);
      check("bp_after_rdy", {31'b0, req_ready}, 32'd1);
      e.res = 32'h8000_0000; e.err = 1'b0; e.lat = 2;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_resp("bp_sll");
      @(negedge clk);
      check("bp_sll_vld1cyc", {31'b0, resp_valid}, 32'd0);
    end

    // Reset during PASS2 of an SRA discards it.
    req_valid  = 1'b1;
    req_op     = 3'd2;
    req_data   = 32'h8000_0000;
    req_shamt  = 5'd4;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rdy", {31'b0, req_ready}, 32'd1);
    check("mid_rst_vld", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_res", resp_result, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) vcount++;
    end
    check("mid_rst_no_resp", vcount, 32'd0);
    run_op("post_rst_sll", 3'd0, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 2);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
